uvmt_cv32e40s_obi_resp_buffer: RTL and testbench

UVMT_CV32E40S_OBI_RESP_BUFFER -- requirements
Module: uvmt_cv32e40s_obi_resp_buffer

---
 rtl/uvmt_cv32e40s_obi_resp_buffer.sv | 145 ++++++++++++++
 tb/tb_uvmt_cv32e40s_obi_resp_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uvmt_cv32e40s_obi_resp_buffer.sv
// OBI response buffer: tracks outstanding transfers, queues memory responses in order,
// and releases each one after a programmable stall with a byte-parity checksum.
module uvmt_cv32e40s_obi_resp_buffer #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STALL_WIDTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic                   mem_rvalid_i,
  input  logic [31:0]            mem_rdata_i,
  input  logic                   mem_err_i,
  input  logic [STALL_WIDTH-1:0] stall_cycles_i,
  output logic                   rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   err_o,
  output logic [4:0]             rchk_o,
  output logic                   protocol_err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_P = PW'(MAX_OUTSTANDING - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  function automatic logic [4:0] calc_rchk(input logic [31:0] data, input logic err);
    calc_rchk = {^{err, 1'b0}, ^data[31:24], ^data[23:16], ^data[15:8], ^data[7:0]};
  endfunction

  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          r_fcnt;
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [31:0]            r_data [MAX_OUTSTANDING];
  logic                   r_err  [MAX_OUTSTANDING];
  logic [1:0]             r_state;
  logic [STALL_WIDTH-1:0] r_dly;
  logic                   r_perr;

  logic w_pop;
  logic w_full;
  logic w_drop;
  logic w_push;
  logic w_inc;

  assign w_pop  = (r_state == S_RESP);
  assign w_full = (r_fcnt == MAX_C);
  // A response with no unanswered transfer behind it is dropped, except the full-FIFO
  // push that coincides with a pop, which simply replaces the departing head.
  assign w_drop = mem_rvalid_i && (r_fcnt == r_cnt) && !(w_full && w_pop);
  assign w_push = mem_rvalid_i && !w_drop;
  // The slot freed by the response leaving this cycle may be granted immediately.
  assign gnt_o  = req_i && !rst && ((r_cnt < MAX_C) || w_pop);
  assign w_inc  = req_i && gnt_o;

  assign rvalid_o       = w_pop;
  assign rdata_o        = w_pop ? r_data[r_rptr] : 32'd0;
  assign err_o          = w_pop ? r_err[r_rptr] : 1'b0;
  assign rchk_o         = w_pop ? calc_rchk(r_data[r_rptr], r_err[r_rptr]) : 5'd0;
  assign protocol_err_o = r_perr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      case ({w_inc, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fcnt <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_perr <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_data[i] <= 32'd0;
        r_err[i]  <= 1'b0;
      end
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CW'(1);
        2'b01:   r_fcnt <= r_fcnt - CW'(1);
        default: r_fcnt <= r_fcnt;
      endcase
      if (w_push) begin
        r_data[r_wptr] <= mem_rdata_i;
        r_err[r_wptr]  <= mem_err_i;
        r_wptr         <= (r_wptr == LAST_P) ? PW'(0) : r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == LAST_P) ? PW'(0) : r_rptr + PW'(1);
      end
      if (w_drop) begin
        r_perr <= 1'b1;
      end
    end
  end

  // Release sequencer: stall_cycles_i is only sampled when leaving IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dly   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_fcnt != '0) begin
            if (stall_cycles_i == '0) begin
              r_state <= S_RESP;
            end else begin
              r_dly   <= stall_cycles_i;
              r_state <= S_DELAY;
            end
          end
        end
        S_DELAY: begin
          if (r_dly == STALL_WIDTH'(1)) begin
            r_dly   <= '0;
            r_state <= S_RESP;
          end else begin
            r_dly <= r_dly - STALL_WIDTH'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_dly   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uvmt_cv32e40s_obi_resp_buffer.sv
// Directed self-checking bench for the OBI response buffer (MAX_OUTSTANDING=2, STALL_WIDTH=4).
module tb_uvmt_cv32e40s_obi_resp_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        mem_err_i = 1'b0;
  logic [3:0]  stall_cycles_i = 4'd0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [4:0]  rchk_o;
  logic        protocol_err_o;

  int n_cmp = 0;
  int n_err = 0;

  uvmt_cv32e40s_obi_resp_buffer #(.MAX_OUTSTANDING(2), .STALL_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .stall_cycles_i(stall_cycles_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .rchk_o(rchk_o), .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are checked at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = 32'd0;
    mem_err_i = 1'b0;
    stall_cycles_i = 4'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_i = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    mem_err_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt_o !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0", gnt_o); end
    n_cmp++; if ({rvalid_o, err_o, protocol_err_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {rvalid_o, err_o, protocol_err_o}); end
    n_cmp++; if ({rdata_o, rchk_o} !== 37'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", {rdata_o, rchk_o}); end
    mem_rvalid_i = 1'b0;
    mem_rdata_i = 32'd0;
    mem_err_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL first_grant: got %b want 1", gnt_o); end
    n_cmp++; if (rvalid_o !== 1'b0) begin n_err++; $display("FAIL first_rvalid: got %b want 0", rvalid_o); end
    next_cycle();
  endtask

  // Single read with no stall, with stall 3, and with a bus error.
  task automatic test_read_vectors();
    logic [3:0]  v_stall [3] = '{4'd0, 4'd3, 4'd0};
    logic [31:0] v_data  [3] = '{32'h0103_070F, 32'h0103_070F, 32'h0000_0000};
    logic        v_err   [3] = '{1'b0, 1'b0, 1'b1};
    logic [4:0]  v_rchk  [3] = '{5'b01010, 5'b01010, 5'b10000};
    for (int v = 0; v < 3; v++) begin
      do_reset();
      stall_cycles_i = v_stall[v];
      for (int c = 0; c < 14; c++) begin
        logic exp_rv;
        req_i = (c == 0);
        mem_rvalid_i = (c == 2);
        mem_rdata_i = (c == 2) ? v_data[v] : 32'd0;
        mem_err_i = (c == 2) ? v_err[v] : 1'b0;
        exp_rv = (c == 4 + int'(v_stall[v]));
        @(negedge clk);
        if (c == 0) begin
          n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL read%0d_gnt: got %b want 1", v, gnt_o); end
        end
        n_cmp++; if (rvalid_o !== exp_rv) begin n_err++; $display("FAIL read%0d_rvalid c%0d: got %b want %b", v, c, rvalid_o, exp_rv); end
        n_cmp++; if (rdata_o !== (exp_rv ? v_data[v] : 32'd0)) begin n_err++; $display("FAIL read%0d_rdata c%0d: got %h", v, c, rdata_o); end
        n_cmp++; if (err_o !== (exp_rv ? v_err[v] : 1'b0)) begin n_err++; $display("FAIL read%0d_err c%0d: got %b", v, c, err_o); end
        n_cmp++; if (rchk_o !== (exp_rv ? v_rchk[v] : 5'd0)) begin n_err++; $display("FAIL read%0d_rchk c%0d: got %b want %b", v, c, rchk_o, exp_rv ? v_rchk[v] : 5'd0); end
        next_cycle();
      end
      n_cmp++; if (protocol_err_o !== 1'b0) begin n_err++; $display("FAIL read%0d_perr: got %b want 0", v, protocol_err_o); end
    end
  endtask

  // Two grants fill the window; the held third request is granted alongside the first response.
  task automatic test_full();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      logic exp_gnt;
      logic exp_rv;
      logic [31:0] exp_d;
      req_i = (c <= 4);
      mem_rvalid_i = (c == 2) || (c == 5) || (c == 8);
      mem_rdata_i = (c == 2) ? 32'hAAAA_0001 : (c == 5) ? 32'hBBBB_0002 : (c == 8) ? 32'hCCCC_0003 : 32'd0;
      exp_gnt = (c <= 4) && (c != 2) && (c != 3);
      exp_rv = (c == 4) || (c == 7) || (c == 10);
      exp_d = (c == 4) ? 32'hAAAA_0001 : (c == 7) ? 32'hBBBB_0002 : (c == 10) ? 32'hCCCC_0003 : 32'd0;
      @(negedge clk);
      n_cmp++; if (gnt_o !== exp_gnt) begin n_err++; $display("FAIL full_gnt c%0d: got %b want %b", c, gnt_o, exp_gnt); end
      n_cmp++; if (rvalid_o !== exp_rv) begin n_err++; $display("FAIL full_rvalid c%0d: got %b want %b", c, rvalid_o, exp_rv); end
      n_cmp++; if (rdata_o !== exp_d) begin n_err++; $display("FAIL full_rdata c%0d: got %h want %h", c, rdata_o, exp_d); end
      next_cycle();
    end
    n_cmp++; if (protocol_err_o !== 1'b0) begin n_err++; $display("FAIL full_perr: got %b want 0", protocol_err_o); end
  endtask

  // Responses on consecutive cycles, including a push into a full FIFO while it pops.
  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      logic exp_rv;
      logic [31:0] exp_d;
      req_i = (c == 0) || (c == 1) || (c == 4);
      mem_rvalid_i = (c >= 2) && (c <= 4);
      mem_rdata_i = (c == 2) ? 32'h1111_1111 : (c == 3) ? 32'h2222_2222 : (c == 4) ? 32'h3333_3333 : 32'd0;
      exp_rv = (c == 4) || (c == 6) || (c == 8);
      exp_d = (c == 4) ? 32'h1111_1111 : (c == 6) ? 32'h2222_2222 : (c == 8) ? 32'h3333_3333 : 32'd0;
      @(negedge clk);
      n_cmp++; if (gnt_o !== req_i) begin n_err++; $display("FAIL b2b_gnt c%0d: got %b want %b", c, gnt_o, req_i); end
      n_cmp++; if (rvalid_o !== exp_rv) begin n_err++; $display("FAIL b2b_rvalid c%0d: got %b want %b", c, rvalid_o, exp_rv); end
      n_cmp++; if (rdata_o !== exp_d) begin n_err++; $display("FAIL b2b_rdata c%0d: got %h want %h", c, rdata_o, exp_d); end
      next_cycle();
    end
    n_cmp++; if (protocol_err_o !== 1'b0) begin n_err++; $display("FAIL b2b_perr: got %b want 0", protocol_err_o); end
  endtask

  // Response with nothing outstanding: dropped and flagged until reset.
  task automatic test_spurious();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      mem_rvalid_i = (c == 0);
      mem_rdata_i = (c == 0) ? 32'hDEAD_BEEF : 32'd0;
      @(negedge clk);
      n_cmp++; if (rvalid_o !== 1'b0) begin n_err++; $display("FAIL spur_rvalid c%0d: got %b want 0", c, rvalid_o); end
      n_cmp++; if (protocol_err_o !== (c >= 1)) begin n_err++; $display("FAIL spur_perr c%0d: got %b want %b", c, protocol_err_o, c >= 1); end
      next_cycle();
    end
    do_reset();
    @(negedge clk);
    n_cmp++; if (protocol_err_o !== 1'b0) begin n_err++; $display("FAIL spur_perr_cleared: got %b want 0", protocol_err_o); end
    next_cycle();
  endtask

  // Asynchronous reset while the response is being stalled discards it.
  task automatic test_reset_mid_delay();
    do_reset();
    stall_cycles_i = 4'd8;
    for (int c = 0; c < 6; c++) begin
      req_i = (c == 0);
      mem_rvalid_i = (c == 2);
      mem_rdata_i = (c == 2) ? 32'h5A5A_5A5A : 32'd0;
      @(negedge clk);
      n_cmp++; if (rvalid_o !== 1'b0) begin n_err++; $display("FAIL mid_pre_rvalid c%0d: got %b want 0", c, rvalid_o); end
      next_cycle();
    end
    req_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (gnt_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_gnt: got %b want 0", gnt_o); end
    n_cmp++; if (rvalid_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_rvalid: got %b want 0", rvalid_o); end
    req_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      req_i = (c == 0) || (c == 3);
      @(negedge clk);
      n_cmp++; if (gnt_o !== req_i) begin n_err++; $display("FAIL mid_post_gnt c%0d: got %b want %b", c, gnt_o, req_i); end
      n_cmp++; if (rvalid_o !== 1'b0) begin n_err++; $display("FAIL mid_post_rvalid c%0d: got %b want 0", c, rvalid_o); end
      next_cycle();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_read_vectors();
    test_full();
    test_back_to_back();
    test_spurious();
    test_reset_mid_delay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
